// File: rtl/vis_prefetch_if.sv
// vis_prefetch_if: read bus towards the correlator blocks plus the readout stream towards the SPI FIFO
//   master: controller side (drives cyc/stb/we/bst/adr/sel and vld/dat/last, samples ack/dat_i/rdy)
//   slave : block array / readout side
interface vis_prefetch_if #(
    parameter int NBLK  = 6,
    parameter int ACCUM = 24,
    parameter int ABITS = 11
);
    logic             cyc_o, stb_o, we_o, bst_o, ack_i;
    logic [ABITS-1:0] adr_o;
    logic [NBLK-1:0]  sel_o;
    logic [ACCUM-1:0] dat_i;
    logic             vld_o, rdy_i, last_o;
    logic [ACCUM-1:0] dat_o;
    modport master(
        output cyc_o, stb_o, we_o, bst_o, adr_o, sel_o, vld_o, dat_o, last_o,
        input  ack_i, dat_i, rdy_i
    );
    modport slave(
        input  cyc_o, stb_o, we_o, bst_o, adr_o, sel_o, vld_o, dat_o, last_o,
        output ack_i, dat_i, rdy_i
    );
endinterface

// File: rtl/vis_prefetch_ctrl.sv
// vis_prefetch_ctrl: drains the completed visibilities bank from every correlator block after a bank switch
//   clk_i, rst : bus clock, synchronous active-high reset
//   en_i       : prefetch enable
//   bank_i     : active bank of block 0, already in the clk_i domain
//   bus        : vis_prefetch_if.master (sequential single reads + valid/ready readout stream)
//   busy_o     : readout in progress
//   ovf_o      : sticky, bank switched again before the readout finished
//   VIS_PREFETCH_BST_EN : when defined, cyc_o is held across a whole block and bst_o hints bulk reads
module vis_prefetch_ctrl #(
    parameter int NBLK  = 6,
    parameter int ACCUM = 24,
    parameter int TRATE = 12,
    parameter int TBITS = 4,
    parameter int BBITS = 4,
    parameter int ABITS = 3 + TBITS + BBITS
) (
    input  logic             clk_i,
    input  logic             rst,
    input  logic             en_i,
    input  logic [BBITS-1:0] bank_i,
    vis_prefetch_if.master   bus,
    output logic             busy_o,
    output logic             ovf_o
);
`ifdef VIS_PREFETCH_BST_EN
    localparam bit BST = 1'b1;
`else
    localparam bit BST = 1'b0;
`endif
    localparam int WBITS = TBITS + 3;
    localparam int BW = $clog2(NBLK + 1);
    localparam logic [WBITS-1:0] WLAST = WBITS'(TRATE * 8 - 1);
    localparam logic [BW-1:0] BLAST = BW'(NBLK - 1);
    typedef enum logic [1:0] {IDLE, REQ, PUSH, NEXT} state_t;
    state_t           state;
    logic [BBITS-1:0] bank_q, pend_bank, rd_bank;
    logic             pending;
    logic [WBITS-1:0] w, w_nx;
    logic [BW-1:0]    b;
    logic [ACCUM-1:0] dat_q;
    logic [ABITS-1:0] adr;
    logic             detect, start, wrap, done;
    assign detect = en_i && bank_i != bank_q;
    assign start = state == IDLE && pending && en_i;
    assign wrap = w == WLAST;
    assign done = wrap && b == BLAST;
    assign w_nx = wrap ? '0 : w + 1'b1;
    // w is already {slot, word}, so the address is a plain concatenation
    assign adr = {rd_bank, w};
    assign bus.adr_o = adr;
    assign bus.sel_o = bus.cyc_o ? NBLK'(1) << b : '0;
    assign bus.we_o = 1'b0;
    assign bus.dat_o = dat_q;
    always_ff @(posedge clk_i) begin
        bank_q <= bank_i;
        if (rst) begin
            state      <= IDLE;
            pending    <= 1'b0;
            pend_bank  <= '0;
            rd_bank    <= '0;
            w          <= '0;
            b          <= '0;
            dat_q      <= '0;
            bus.cyc_o  <= 1'b0;
            bus.stb_o  <= 1'b0;
            bus.bst_o  <= 1'b0;
            bus.vld_o  <= 1'b0;
            bus.last_o <= 1'b0;
            busy_o     <= 1'b0;
            ovf_o      <= 1'b0;
        end else begin
            // a newer switch overwrites the queued bank: only one switch is held
            pending <= detect || (pending && !start);
            if (detect) begin
                pend_bank <= bank_q;
                if (busy_o) ovf_o <= 1'b1;
            end
            case (state)
                IDLE: if (start) begin
                    rd_bank   <= pend_bank;
                    w         <= '0;
                    b         <= '0;
                    busy_o    <= 1'b1;
                    bus.cyc_o <= 1'b1;
                    bus.stb_o <= 1'b1;
                    bus.bst_o <= BST;
                    state     <= REQ;
                end
                REQ: if (bus.ack_i) begin
                    dat_q      <= bus.dat_i;
                    bus.stb_o  <= 1'b0;
                    bus.bst_o  <= 1'b0;
                    bus.cyc_o  <= BST && !wrap;
                    bus.vld_o  <= 1'b1;
                    bus.last_o <= done;
                    state      <= PUSH;
                end
                PUSH: if (bus.rdy_i) begin
                    bus.vld_o  <= 1'b0;
                    bus.last_o <= 1'b0;
                    state      <= NEXT;
                end
                NEXT: begin
                    w <= w_nx;
                    if (wrap) b <= b + 1'b1;
                    if (done) begin
                        busy_o <= 1'b0;
                        state  <= IDLE;
                    end else begin
                        bus.cyc_o <= 1'b1;
                        bus.stb_o <= 1'b1;
                        bus.bst_o <= BST && w_nx != WLAST;
                        state     <= REQ;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_vis_prefetch_ctrl.sv
// tb_vis_prefetch_ctrl: directed bench for vis_prefetch_ctrl with a 2-cycle-latency block model and a stream scoreboard
module tb_vis_prefetch_ctrl;
`ifdef VIS_PREFETCH_BST_EN
    localparam bit BST = 1'b1;
`else
    localparam bit BST = 1'b0;
`endif
    localparam int WORDS = 576;
    logic       clk = 1'b0;
    logic       rst, en, busy, ovf;
    logic [3:0] bank;
    int         checks = 0, failures = 0;
    int         k = 0, rd_done = 0, cyc_falls = 0, bst_bad = 0, lat_cnt = 0;
    logic       prev_cyc = 1'b0, seen;
    logic [3:0] exp_q[$];
    logic [10:0] last_adr = '0, hold_adr;
    logic [5:0]  last_sel = '0;
    logic [23:0] hold_dat;
    vis_prefetch_if bus();
    vis_prefetch_ctrl dut (
        .clk_i (clk),
        .rst   (rst),
        .en_i  (en),
        .bank_i(bank),
        .bus   (bus),
        .busy_o(busy),
        .ovf_o (ovf)
    );
    always #5 clk = ~clk;
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask
    // block array: acks two cycles after the strobe, data encodes {sel, adr}
    always @(negedge clk) begin
        if (bus.ack_i || !bus.stb_o) begin
            bus.ack_i = 1'b0;
            lat_cnt = 0;
        end else if (++lat_cnt >= 2) begin
            bus.ack_i = 1'b1;
            bus.dat_i = {bus.sel_o, bus.adr_o, 7'h55};
            last_adr = bus.adr_o;
            last_sel = bus.sel_o;
            lat_cnt = 0;
        end
    end
    // stream scoreboard: word k of a readout is block k/96, word k%96 of the expected bank
    always @(negedge clk) begin
        #1;
        if (prev_cyc && !bus.cyc_o) cyc_falls++;
        prev_cyc = bus.cyc_o;
        if (bus.bst_o !== (BST && bus.stb_o && (k % 96) != 95)) bst_bad++;
        if (bus.vld_o && bus.rdy_i) begin
            if (exp_q.size() == 0) check("unexpected_word", exp_q.size(), 1);
            else begin
                check("dat", bus.dat_o, {6'(1 << (k / 96)), exp_q[0], 7'(k % 96), 7'h55});
                check("last", bus.last_o, k == WORDS - 1);
                k++;
                if (k == WORDS) begin
                    k = 0;
                    void'(exp_q.pop_front());
                    rd_done++;
                end
            end
        end
    end
    initial begin
        rst = 1'b1;
        en = 1'b0;
        bank = 4'd0;
        bus.rdy_i = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_cyc", bus.cyc_o, 0);
        check("rst_stb", bus.stb_o, 0);
        check("rst_vld", bus.vld_o, 0);
        check("rst_last", bus.last_o, 0);
        check("rst_bst", bus.bst_o, 0);
        check("rst_we", bus.we_o, 0);
        check("rst_sel", bus.sel_o, 0);
        check("rst_adr", bus.adr_o, 0);
        check("rst_dat", bus.dat_o, 0);
        check("rst_busy", busy, 0);
        check("rst_ovf", ovf, 0);
        rst = 1'b0;
        en = 1'b1;
        exp_q.push_back(4'd0);
        cyc_falls = 0;
        @(negedge clk);
        bank = 4'd1;
        for (int i = 0; i < 10 && !bus.stb_o; i++) @(negedge clk);
        check("first_stb", bus.stb_o, 1);
        check("first_adr", bus.adr_o, 11'h000);
        check("first_sel", bus.sel_o, 6'b000001);
        check("first_busy", busy, 1);
        for (int i = 0; i < 1000 && !(bus.stb_o && k == 37); i++) @(negedge clk);
        check("reach_w37", bus.stb_o && k == 37, 1);
        bus.rdy_i = 1'b0;
        for (int i = 0; i < 10 && !bus.vld_o; i++) @(negedge clk);
        check("vld_w37", bus.vld_o, 1);
        hold_dat = bus.dat_o;
        hold_adr = bus.adr_o;
        check("w37_dat", hold_dat, {6'b000001, 4'h0, 7'd37, 7'h55});
        repeat (10) begin
            @(negedge clk);
            check("stall_vld", bus.vld_o, 1);
            check("stall_dat", bus.dat_o, hold_dat);
            check("stall_adr", bus.adr_o, hold_adr);
            check("stall_stb", bus.stb_o, 0);
        end
        bus.rdy_i = 1'b1;
        for (int i = 0; i < 2000 && !(bus.stb_o && k == 200); i++) @(negedge clk);
        check("reach_w200", bus.stb_o && k == 200, 1);
        exp_q.push_back(4'd1);
        bank = 4'd2;
        @(negedge clk);
        check("ovf_set", ovf, 1);
        check("ovf_busy", busy, 1);
        for (int i = 0; i < 5000 && busy; i++) @(negedge clk);
        check("rd0_busy_fall", busy, 0);
        check("rd0_done", rd_done, 1);
        check("rd0_last_adr", last_adr, {4'h0, 4'hB, 3'h7});
        check("rd0_last_sel", last_sel, 6'b100000);
        check("rd0_cyc_falls", cyc_falls, BST ? 6 : WORDS);
        check("ovf_sticky", ovf, 1);
        cyc_falls = 0;
        @(negedge clk);
        check("rd1_busy", busy, 1);
        check("rd1_stb", bus.stb_o, 1);
        check("rd1_adr", bus.adr_o, {4'h1, 7'h00});
        check("rd1_sel", bus.sel_o, 6'b000001);
        for (int i = 0; i < 5000 && busy; i++) @(negedge clk);
        check("rd1_busy_fall", busy, 0);
        check("rd1_done", rd_done, 2);
        check("rd1_cyc_falls", cyc_falls, BST ? 6 : WORDS);
        en = 1'b0;
        bank = 4'd3;
        seen = 1'b0;
        repeat (20) begin
            @(negedge clk);
            seen = seen | bus.cyc_o | busy | bus.vld_o;
        end
        check("dis_quiet", seen, 0);
        en = 1'b1;
        exp_q.push_back(4'd3);
        bank = 4'd4;
        for (int i = 0; i < 1000 && !(bus.stb_o && k == 50); i++) @(negedge clk);
        check("reach_w50", bus.stb_o && k == 50, 1);
        rst = 1'b1;
        @(negedge clk);
        check("mid_rst_cyc", bus.cyc_o, 0);
        check("mid_rst_stb", bus.stb_o, 0);
        check("mid_rst_vld", bus.vld_o, 0);
        check("mid_rst_sel", bus.sel_o, 0);
        check("mid_rst_adr", bus.adr_o, 0);
        check("mid_rst_busy", busy, 0);
        check("mid_rst_ovf", ovf, 0);
        exp_q.delete();
        k = 0;
        rst = 1'b0;
        exp_q.push_back(4'd4);
        @(negedge clk);
        bank = 4'd5;
        for (int i = 0; i < 10 && !bus.stb_o; i++) @(negedge clk);
        check("restart_stb", bus.stb_o, 1);
        check("restart_adr", bus.adr_o, {4'h4, 7'h00});
        check("restart_sel", bus.sel_o, 6'b000001);
        for (int i = 0; i < 5000 && busy; i++) @(negedge clk);
        check("rd2_busy_fall", busy, 0);
        check("rd2_done", rd_done, 3);
        check("queue_empty", exp_q.size(), 0);
        check("bst_pattern", bst_bad, 0);
        check("ovf_clear", ovf, 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
